// File: rtl/tm1640_rx.sv
// TM1640 bus receiver: synchronizes the two-wire bus, decodes command and data
// frames, and keeps a 16-byte display RAM with a registered read port.
module tm1640_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tm_clk,
    input  logic       tm_din,
    output logic       rx_valid,
    output logic [7:0] rx_byte,
    output logic       wr_strobe,
    output logic [3:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       disp_on,
    output logic [2:0] brightness,
    input  logic [3:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       frame_err
);

    // CMD_DONE follows a mode or display-control byte: any further byte is an error.
    typedef enum logic [2:0] {IDLE, CMD, CMD_DONE, DATA, IGNORE} state_t;

    logic [SYNC_STAGES-1:0] clkSync_q, dinSync_q;
    logic                   sClkD_q, sDinD_q;
    logic                   sClk, sDin;
    logic                   startDet, stopDet, bitRise, byteDone, partialErr;
    logic [7:0]             fullByte;

    state_t                 state_q, state_d;
    logic                   setMode, setCtrl, loadPtr, doWrite, cmdErr;

    logic [2:0]             bitCnt_q;
    logic [7:0]             shift_q;
    logic [3:0]             ptr_q;
    logic                   autoInc_q, dispOn_q;
    logic [2:0]             brightness_q;
    logic [7:0]             ram_q [16];
    logic                   rxValid_q, wrStrobe_q, frameErr_q;
    logic [7:0]             rxByte_q, wrData_q, rdData_q;
    logic [3:0]             wrAddr_q;

    // Synchronizers are left unreset so they always track the live bus level;
    // resetting them could fabricate a START/STOP edge on release.
    always_ff @(posedge clk) begin
        clkSync_q <= {clkSync_q[SYNC_STAGES-2:0], tm_clk};
        dinSync_q <= {dinSync_q[SYNC_STAGES-2:0], tm_din};
        sClkD_q   <= clkSync_q[SYNC_STAGES-1];
        sDinD_q   <= dinSync_q[SYNC_STAGES-1];
    end

    assign sClk       = clkSync_q[SYNC_STAGES-1];
    assign sDin       = dinSync_q[SYNC_STAGES-1];
    assign startDet   = sClk & sClkD_q & sDinD_q & ~sDin;
    assign stopDet    = sClk & sClkD_q & ~sDinD_q & sDin;
    assign bitRise    = sClk & ~sClkD_q & (state_q != IDLE);
    assign byteDone   = bitRise & (bitCnt_q == 3'd7);
    assign fullByte   = {sDin, shift_q[7:1]};
    assign partialErr = (startDet | stopDet) & (bitCnt_q != 3'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (startDet) begin
            state_d = CMD;
        end else if (stopDet) begin
            state_d = IDLE;
        end else if (byteDone) begin
            case (state_q)
                CMD: begin
                    case (fullByte[7:6])
                        2'b00:   state_d = IGNORE;
                        2'b11:   state_d = DATA;
                        default: state_d = CMD_DONE;
                    endcase
                end
                CMD_DONE: state_d = IGNORE;
                default:  state_d = state_q;
            endcase
        end
    end

    always_comb begin
        setMode = 1'b0;
        setCtrl = 1'b0;
        loadPtr = 1'b0;
        doWrite = 1'b0;
        cmdErr  = 1'b0;
        if (byteDone) begin
            case (state_q)
                CMD: begin
                    case (fullByte[7:6])
                        2'b00:   cmdErr  = 1'b1;
                        2'b01:   setMode = 1'b1;
                        2'b10:   setCtrl = 1'b1;
                        default: loadPtr = 1'b1;
                    endcase
                end
                DATA:     doWrite = 1'b1;
                CMD_DONE: cmdErr  = 1'b1;
                default:  ;
            endcase
        end
    end

    // Every decoded effect is registered on the same edge as rx_valid, so the
    // strobes, settings and RAM contents all become visible together.
    always_ff @(posedge clk) begin
        if (rst) begin
            bitCnt_q     <= 3'd0;
            shift_q      <= 8'h00;
            ptr_q        <= 4'd0;
            autoInc_q    <= 1'b1;
            dispOn_q     <= 1'b0;
            brightness_q <= 3'd0;
            rxValid_q    <= 1'b0;
            rxByte_q     <= 8'h00;
            wrStrobe_q   <= 1'b0;
            wrAddr_q     <= 4'd0;
            wrData_q     <= 8'h00;
            frameErr_q   <= 1'b0;
            rdData_q     <= 8'h00;
            for (int i = 0; i < 16; i++) begin
                ram_q[i] <= 8'h00;
            end
        end else begin
            rxValid_q  <= 1'b0;
            wrStrobe_q <= 1'b0;
            frameErr_q <= cmdErr | partialErr;

            if (startDet || stopDet) begin
                bitCnt_q <= 3'd0;
            end else if (bitRise) begin
                shift_q  <= fullByte;
                bitCnt_q <= bitCnt_q + 3'd1;
            end

            if (byteDone) begin
                rxValid_q <= 1'b1;
                rxByte_q  <= fullByte;
            end
            if (setMode) begin
                autoInc_q <= ~fullByte[2];
            end
            if (setCtrl) begin
                dispOn_q     <= fullByte[3];
                brightness_q <= fullByte[2:0];
            end
            if (loadPtr) begin
                ptr_q <= fullByte[3:0];
            end
            if (doWrite) begin
                ram_q[ptr_q] <= fullByte;
                wrStrobe_q   <= 1'b1;
                wrAddr_q     <= ptr_q;
                wrData_q     <= fullByte;
                if (autoInc_q) begin
                    ptr_q <= ptr_q + 4'd1;
                end
            end

            rdData_q <= ram_q[rd_addr];
        end
    end

    assign rx_valid   = rxValid_q;
    assign rx_byte    = rxByte_q;
    assign wr_strobe  = wrStrobe_q;
    assign wr_addr    = wrAddr_q;
    assign wr_data    = wrData_q;
    assign disp_on    = dispOn_q;
    assign brightness = brightness_q;
    assign rd_data    = rdData_q;
    assign frame_err  = frameErr_q;

endmodule

// File: tb/tb_tm1640_rx.sv
// Bench for tm1640_rx: drives TM1640 frames bit by bit and compares observed
// bytes, writes, errors, settings and RAM against a byte-level frame model.
module tb_tm1640_rx;

    localparam int SYNC = 2;
    localparam int HALF = 5;

    typedef enum {M_CMD, M_DATA, M_DONE, M_IGNORE} mState_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tmClk = 1'b1;
    logic       tmDin = 1'b1;
    logic [3:0] rdAddr = 4'd0;
    logic       rxValid, wrStrobe, dispOn, frameErr;
    logic [7:0] rxByte, wrData, rdData;
    logic [3:0] wrAddr;
    logic [2:0] brightness;

    int checks = 0;
    int failures = 0;

    logic [7:0]  txQ[$];
    logic [7:0]  expRx[$], obsRx[$];
    logic [11:0] expWr[$], obsWr[$];
    logic [7:0]  expColl[$], obsColl[$];
    int          expErr = 0;
    int          obsErr = 0;
    logic [3:0]  collAddr = 4'd0;

    logic [7:0]  modelRam [16];
    logic [3:0]  modelPtr;
    logic        modelAuto, modelDisp;
    logic [2:0]  modelBri;

    logic [7:0]  frame37 [10] = '{8'hC0, 8'h06, 8'h5B, 8'h4F, 8'h66,
                                  8'h6D, 8'h7C, 8'h07, 8'h7F, 8'h6F};

    tm1640_rx #(.SYNC_STAGES(SYNC)) dut (
        .clk        (clk),
        .rst        (rst),
        .tm_clk     (tmClk),
        .tm_din     (tmDin),
        .rx_valid   (rxValid),
        .rx_byte    (rxByte),
        .wr_strobe  (wrStrobe),
        .wr_addr    (wrAddr),
        .wr_data    (wrData),
        .disp_on    (dispOn),
        .brightness (brightness),
        .rd_addr    (rdAddr),
        .rd_data    (rdData),
        .frame_err  (frameErr)
    );

    always #5 clk = ~clk;

    // Collisions are recorded only when the held read address matches the write.
    always @(negedge clk) begin
        if (!rst) begin
            if (rxValid) obsRx.push_back(rxByte);
            if (wrStrobe) begin
                obsWr.push_back({wrAddr, wrData});
                if (wrAddr == collAddr) obsColl.push_back(rdData);
            end
            if (frameErr) obsErr++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    function automatic void modelReset();
        for (int i = 0; i < 16; i++) modelRam[i] = 8'h00;
        modelPtr  = 4'd0;
        modelAuto = 1'b1;
        modelDisp = 1'b0;
        modelBri  = 3'd0;
        expRx.delete();
        expWr.delete();
        expColl.delete();
        expErr = 0;
    endfunction

    function automatic void modelFrame(input int partialBits);
        mState_t st = M_CMD;
        foreach (txQ[i]) begin
            logic [7:0] b;
            b = txQ[i];
            expRx.push_back(b);
            case (st)
                M_CMD: begin
                    case (b[7:6])
                        2'b00: begin expErr++; st = M_IGNORE; end
                        2'b01: begin modelAuto = ~b[2]; st = M_DONE; end
                        2'b10: begin modelDisp = b[3]; modelBri = b[2:0]; st = M_DONE; end
                        default: begin modelPtr = b[3:0]; st = M_DATA; end
                    endcase
                end
                M_DATA: begin
                    if (modelPtr == collAddr) expColl.push_back(modelRam[modelPtr]);
                    modelRam[modelPtr] = b;
                    expWr.push_back({modelPtr, b});
                    if (modelAuto) modelPtr = modelPtr + 4'd1;
                end
                M_DONE: begin expErr++; st = M_IGNORE; end
                default: ;
            endcase
        end
        if (partialBits != 0) expErr++;
    endfunction

    task automatic halfWait();
        repeat (HALF) @(negedge clk);
    endtask

    task automatic busStart();
        tmDin = 1'b0;
        halfWait();
    endtask

    task automatic sendBit(input logic b);
        tmClk = 1'b0;
        halfWait();
        tmDin = b;
        halfWait();
        tmClk = 1'b1;
        halfWait();
    endtask

    task automatic sendByte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) sendBit(b[i]);
    endtask

    // With tm_clk left high, a high data line must dip first (a harmless START).
    task automatic busStop();
        if (tmDin) begin
            tmDin = 1'b0;
            halfWait();
        end
        tmDin = 1'b1;
        halfWait();
        halfWait();
    endtask

    task automatic applyStimulus(input int partialBits);
        rdAddr = collAddr;
        modelFrame(partialBits);
        busStart();
        foreach (txQ[i]) sendByte(txQ[i]);
        for (int i = 0; i < partialBits; i++) sendBit($urandom_range(0, 1) == 1);
        busStop();
        txQ.delete();
    endtask

    task automatic readRam(input logic [3:0] a, output logic [7:0] v);
        @(negedge clk);
        rdAddr = a;
        @(negedge clk);
        v = rdData;
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_rxValid"}, 32'(rxValid), 32'd0);
        checkOutput({tag, "_rxByte"}, 32'(rxByte), 32'd0);
        checkOutput({tag, "_wrStrobe"}, 32'(wrStrobe), 32'd0);
        checkOutput({tag, "_wrAddr"}, 32'(wrAddr), 32'd0);
        checkOutput({tag, "_wrData"}, 32'(wrData), 32'd0);
        checkOutput({tag, "_dispOn"}, 32'(dispOn), 32'd0);
        checkOutput({tag, "_brightness"}, 32'(brightness), 32'd0);
        checkOutput({tag, "_rdData"}, 32'(rdData), 32'd0);
        checkOutput({tag, "_frameErr"}, 32'(frameErr), 32'd0);
    endtask

    task automatic verifyScoreboard(input string tag);
        logic [7:0] v;
        repeat (4) @(negedge clk);
        checkOutput({tag, "_rxCount"}, 32'(obsRx.size()), 32'(expRx.size()));
        for (int i = 0; i < obsRx.size() && i < expRx.size(); i++)
            checkOutput({tag, "_rxByte"}, 32'(obsRx[i]), 32'(expRx[i]));
        checkOutput({tag, "_wrCount"}, 32'(obsWr.size()), 32'(expWr.size()));
        for (int i = 0; i < obsWr.size() && i < expWr.size(); i++)
            checkOutput({tag, "_wrAddrData"}, 32'(obsWr[i]), 32'(expWr[i]));
        checkOutput({tag, "_collCount"}, 32'(obsColl.size()), 32'(expColl.size()));
        for (int i = 0; i < obsColl.size() && i < expColl.size(); i++)
            checkOutput({tag, "_collOld"}, 32'(obsColl[i]), 32'(expColl[i]));
        checkOutput({tag, "_errCount"}, 32'(obsErr), 32'(expErr));
        checkOutput({tag, "_dispOn"}, 32'(dispOn), 32'(modelDisp));
        checkOutput({tag, "_brightness"}, 32'(brightness), 32'(modelBri));
        for (int a = 0; a < 16; a++) begin
            readRam(4'(a), v);
            checkOutput({tag, "_ram"}, 32'(v), 32'(modelRam[a]));
        end
        obsRx.delete(); expRx.delete();
        obsWr.delete(); expWr.delete();
        obsColl.delete(); expColl.delete();
        obsErr = 0; expErr = 0;
    endtask

    initial begin
        logic [7:0] v;
        int kind, n, pb;

        modelReset();
        repeat (6) @(negedge clk);
        checkReset("reset");
        rst = 1'b0;
        repeat (4) @(negedge clk);

        $display("[TB] address auto-increment out of reset");
        collAddr = 4'd3;
        txQ.push_back(8'hC2); txQ.push_back(8'h11); txQ.push_back(8'h22);
        applyStimulus(0);
        verifyScoreboard("autoIncDefault");

        $display("[TB] fixed-address mode");
        collAddr = 4'd5;
        txQ.push_back(8'h44);
        applyStimulus(0);
        txQ.push_back(8'hC5); txQ.push_back(8'h11); txQ.push_back(8'h22);
        applyStimulus(0);
        verifyScoreboard("fixedAddr");
        readRam(4'd5, v); checkOutput("fixedAddr_ram5", 32'(v), 32'h22);
        readRam(4'd6, v); checkOutput("fixedAddr_ram6", 32'(v), 32'h00);

        $display("[TB] address wrap");
        collAddr = 4'd0;
        txQ.push_back(8'h40);
        applyStimulus(0);
        txQ.push_back(8'hCF); txQ.push_back(8'hA1); txQ.push_back(8'hA2); txQ.push_back(8'hA3);
        applyStimulus(0);
        verifyScoreboard("wrap");
        readRam(4'd15, v); checkOutput("wrap_ram15", 32'(v), 32'hA1);
        readRam(4'd0, v);  checkOutput("wrap_ram0", 32'(v), 32'hA2);
        readRam(4'd1, v);  checkOutput("wrap_ram1", 32'(v), 32'hA3);

        $display("[TB] partial byte");
        applyStimulus(5);
        verifyScoreboard("partial");

        $display("[TB] invalid command then recovery");
        txQ.push_back(8'h00); txQ.push_back(8'h55);
        applyStimulus(0);
        txQ.push_back(8'hC3); txQ.push_back(8'h99);
        applyStimulus(0);
        verifyScoreboard("badCmd");
        readRam(4'd3, v); checkOutput("badCmd_ram3", 32'(v), 32'h99);

        $display("[TB] randomized frames");
        for (int it = 0; it < 20; it++) begin
            kind = $urandom_range(0, 4);
            collAddr = 4'($urandom_range(0, 15));
            pb = 0;
            case (kind)
                0: begin
                    txQ.push_back(8'h40 | 8'($urandom_range(0, 63)));
                    if ($urandom_range(0, 2) == 0) txQ.push_back(8'($urandom()));
                end
                1: txQ.push_back(8'h80 | 8'($urandom_range(0, 63)));
                2: begin
                    txQ.push_back(8'hC0 | 8'($urandom_range(0, 63)));
                    n = $urandom_range(0, 5);
                    for (int k = 0; k < n; k++) txQ.push_back(8'($urandom()));
                    pb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0;
                end
                3: begin
                    txQ.push_back(8'($urandom_range(0, 63)));
                    n = $urandom_range(0, 2);
                    for (int k = 0; k < n; k++) txQ.push_back(8'($urandom()));
                end
                default: pb = $urandom_range(1, 7);
            endcase
            applyStimulus(pb);
            verifyScoreboard("random");
        end

        $display("[TB] reset in the middle of a data byte");
        busStart();
        sendByte(8'hC4);
        sendByte(8'h3C);
        sendBit(1'b1); sendBit(1'b0); sendBit(1'b0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkReset("midFrameReset");
        rst = 1'b0;
        tmDin = 1'b1;
        halfWait();
        obsRx.delete(); obsWr.delete(); obsColl.delete(); obsErr = 0;
        modelReset();
        verifyScoreboard("postReset");

        collAddr = 4'd8;
        txQ.push_back(8'h42);
        applyStimulus(0);
        for (int i = 0; i < 10; i++) txQ.push_back(frame37[i]);
        applyStimulus(0);
        txQ.push_back(8'h8F);
        applyStimulus(0);
        checkOutput("digits_dispOn", 32'(dispOn), 32'd1);
        checkOutput("digits_brightness", 32'(brightness), 32'd7);
        checkOutput("digits_wrCount", 32'(obsWr.size()), 32'd9);
        verifyScoreboard("digits");
        readRam(4'd0, v); checkOutput("digits_ram0", 32'(v), 32'h06);
        readRam(4'd8, v); checkOutput("digits_ram8", 32'(v), 32'h6F);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
